mem_line_responder: RTL
=======================

Name: mem_line_responder

Overview:
- Synthesizable memory-side responder for the C2 line bus: the far end of the cache's memory port.
- Accepts C2_READ_LINE and C2_WRITE_LINE from the cache, which initiates.
- Models a fixed access latency, stores whole lines, and answers with C2_RESPONSE.
- Sits between the cache and the backing store. Replaces the behavioural memory model in synthesizable builds and benches.

Parameters:
ADDR_W, 14, line-address bits (tag+set) on addr
LINE_BYTES, 16, bytes per cache line
BUS_BYTES, 2, bytes per data beat; N_BEATS = LINE_BYTES/BUS_BYTES
MEM_LINES, 1024, lines of storage; the line index is addr modulo MEM_LINES
LATENCY, 100, idle cycles between request completion and first response beat

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
addr  in  ADDR_W  line address, valid in the request's first cycle
cmd_in  in  2  C2 command driven by the initiator
cmd_out  out  2  C2 command driven by this block
cmd_oe  out  1  1 = this block owns cmd/data bus
data_in  in  8*BUS_BYTES  write beats from the initiator
data_out  out  8*BUS_BYTES  read beats to the initiator
busy  out  1  1 whenever state != IDLE
err  out  1  sticky protocol-violation flag

Behaviour:
Reset (reset low, asynchronous):
- state=IDLE; cmd_oe=0; cmd_out=C2_NOP; data_out=0; busy=0; err=0; beat and latency counters cleared.
- Storage contents are not reset.
- Reset mid-transaction abandons it. A partially captured write does not commit.

Bus-level rules:
- When cmd_oe=0 the bench/wrapper tri-states cmd_out/data_out; the initiator owns the bus.
- Commands are sampled only in IDLE.

State machine:
IDLE:
- cmd_in=C2_READ_LINE: latch addr → WAIT (kind=read).
- cmd_in=C2_WRITE_LINE: latch addr, store data_in as beat 0, beat=1. Go to WR_CAP, or straight to WAIT if N_BEATS=1.
- C2_NOP or C2_RESPONSE in IDLE: ignored.
WR_CAP:
- Each cycle store data_in at byte offset beat*BUS_BYTES, then beat++.
- cmd_in must stay C2_WRITE_LINE. Any other value sets err, and the beat is still captured.
- After beat N_BEATS-1: commit the full line to storage in one write → WAIT (kind=write).
WAIT:
- Count LATENCY cycles.
- LATENCY=0 leaves WAIT after one cycle.
- Commands arriving in WAIT, RESP_RD or RESP_WR set err and are otherwise ignored.
RESP_WR:
- One cycle with cmd_oe=1, cmd_out=C2_RESPONSE → RELEASE.
RESP_RD:
- N_BEATS cycles with cmd_oe=1, cmd_out=C2_RESPONSE, data_out = beat i of the line, in ascending byte order (beat 0 = bytes 0..BUS_BYTES-1).
- After the last beat → RELEASE.
RELEASE:
- One cycle with cmd_oe=0, cmd_out=C2_NOP (bus turnaround) → IDLE.

Timing (request sampled at edge k, last write beat sampled at edge k):
- Read: first RESPONSE beat visible after edge k+1+LATENCY. Last beat after edge k+LATENCY+N_BEATS.
- Write: single RESPONSE cycle after edge k+1+LATENCY.
- Read-after-write to the same line returns the new data. The commit precedes WAIT, so there is no hazard.

Arithmetic and width rules:
- Line index = addr[$clog2(MEM_LINES)-1:0]; upper addr bits are ignored (wrap).
- Beat counter width = $clog2(N_BEATS)+1. Latency counter width = $clog2(LATENCY+1)+1.
- LINE_BYTES must be a multiple of BUS_BYTES; otherwise elaboration fails via $error.

Decomposition:
- Shared package mem_bus_pkg:
  - C2 command enum: C2_NOP=2'd0, C2_RESPONSE=2'd1, C2_READ_LINE=2'd2, C2_WRITE_LINE=2'd3.
  - BITS_IN_BYTE.
  - Responder state enum.
  - Also used by the cache and benches.
- Sub-module mem_line_ram:
  - MEM_LINES x LINE_BYTES array, one full-line write port, one combinational line read port.
  - No reset.

Test Plan:
- Reset sequence: reset low for 2 cycles mid-read (during WAIT) → cmd_oe=0, busy=0, err=0 immediately; next request served normally.
- Write then read: WRITE_LINE addr=0x2A5, beats 0x0100,0x0302,…,0x0F0E, then READ_LINE 0x2A5 → RESPONSE exactly at k+1+LATENCY; beats match in order; RESPONSE lasts 8 cycles; one RELEASE cycle before the bus is free.
- Write ack timing with LATENCY=3: WRITE_LINE addr=0x001, 8 beats of 0xBEEF → single RESPONSE cycle 4 edges after the last beat; busy falls after RELEASE.
- Address wrap with MEM_LINES=1024: write pattern 0xA5A5 to addr 0x0005, read addr 0x0405 (aliases) → all beats 0xA5A5.
- Protocol violation: READ_LINE issued while in WAIT → err=1 and stays 1; the original read still completes with correct data.
- LATENCY=0, N_BEATS=1 (LINE_BYTES=BUS_BYTES=2): write 0x1234, read back → RESPONSE on the cycle after the request; data_out=0x1234.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Purpose : shared C2 line-bus definitions (commands, byte width, responder states).
// Latency : n/a (types and constants only).
// Backpr. : n/a. Used by the responder, the cache side and benches.
package mem_bus_pkg;

    localparam int BITS_IN_BYTE = 8;

    typedef enum logic [1:0] {
        C2_NOP        = 2'd0,
        C2_RESPONSE   = 2'd1,
        C2_READ_LINE  = 2'd2,
        C2_WRITE_LINE = 2'd3
    } c2_cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_CAP,
        ST_WAIT,
        ST_RESP_RD,
        ST_RESP_WR,
        ST_RELEASE
    } resp_state_e;

endpackage

// File: rtl/mem_line_ram.sv
// Purpose : MEM_LINES x LINE_BYTES line store, one full-line write port, one async read port.
// Latency : write lands on the rising edge; read is combinational from raddr_i.
// Backpr. : none, always accepts a write. No reset, contents survive reset.
// Ports   : clk; we_i/waddr_i/wdata_i write port; raddr_i/rdata_o read port.
module mem_line_ram
    import mem_bus_pkg::*;
#(
    parameter int MEM_LINES  = 1024,
    parameter int LINE_BYTES = 16,
    localparam int IDX_W     = $clog2(MEM_LINES),
    localparam int LINE_W    = LINE_BYTES * BITS_IN_BYTE
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  waddr_i,
    input  logic [LINE_W-1:0] wdata_i,
    input  logic [IDX_W-1:0]  raddr_i,
    output logic [LINE_W-1:0] rdata_o
);

    logic [LINE_W-1:0] mem_q [MEM_LINES];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mem_line_responder.sv
// Purpose : memory-side C2 responder; captures write lines, serves read lines from mem_line_ram.
// Latency : first RESPONSE beat LATENCY+1 cycles after the request / last write beat is sampled.
// Backpr. : none; requests are only sampled in IDLE, requests while busy only raise sticky err.
// Ports   : clk, reset (async active-low); addr/cmd_in/data_in from initiator;
//           cmd_out/cmd_oe/data_out drive the shared bus; busy = not IDLE; err = protocol violation.
module mem_line_responder
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W     = 14,
    parameter int LINE_BYTES = 16,
    parameter int BUS_BYTES  = 2,
    parameter int MEM_LINES  = 1024,
    parameter int LATENCY    = 100
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [ADDR_W-1:0]             addr,
    input  logic [1:0]                    cmd_in,
    output logic [1:0]                    cmd_out,
    output logic                          cmd_oe,
    input  logic [BITS_IN_BYTE*BUS_BYTES-1:0] data_in,
    output logic [BITS_IN_BYTE*BUS_BYTES-1:0] data_out,
    output logic                          busy,
    output logic                          err
);

    localparam int N_BEATS = LINE_BYTES / BUS_BYTES;
    localparam int BUS_W   = BUS_BYTES * BITS_IN_BYTE;
    localparam int LINE_W  = LINE_BYTES * BITS_IN_BYTE;
    localparam int IDX_W   = $clog2(MEM_LINES);
    localparam int BEAT_W  = $clog2(N_BEATS) + 1;
    localparam int LAT_W   = $clog2(LATENCY + 1) + 1;

    if (LINE_BYTES % BUS_BYTES != 0) begin : g_bad_geometry
        $error("mem_line_responder: LINE_BYTES must be a multiple of BUS_BYTES");
    end

    resp_state_e       state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic [IDX_W-1:0]  addr_q, addr_d;
    logic              kind_wr_q, kind_wr_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic              err_q, err_d;

    logic              ram_we;
    logic [IDX_W-1:0]  ram_waddr;
    logic [LINE_W-1:0] ram_rdata;

    // Upper address bits alias onto the same line (wrap); only the index is kept.
    logic [IDX_W-1:0]  req_idx;
    logic              unused_addr;
    logic              cmd_is_req;

    assign req_idx     = addr[IDX_W-1:0];
    assign unused_addr = ^addr;
    assign cmd_is_req  = (cmd_in == C2_READ_LINE) || (cmd_in == C2_WRITE_LINE);

    mem_line_ram #(
        .MEM_LINES  (MEM_LINES),
        .LINE_BYTES (LINE_BYTES)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (line_d),
        .raddr_i (addr_q),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            beat_q    <= '0;
            lat_q     <= '0;
            addr_q    <= '0;
            kind_wr_q <= 1'b0;
            line_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            lat_q     <= lat_d;
            addr_q    <= addr_d;
            kind_wr_q <= kind_wr_d;
            line_q    <= line_d;
            err_q     <= err_d;
        end
    end

    // The RAM is written with line_d, i.e. the buffered beats with the current
    // beat merged in, so the last beat commits in the same cycle it arrives and
    // a following read of that line already sees the new data.
    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        lat_d     = lat_q;
        addr_d    = addr_q;
        kind_wr_d = kind_wr_q;
        line_d    = line_q;
        err_d     = err_q;
        ram_we    = 1'b0;
        ram_waddr = addr_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_in == C2_READ_LINE) begin
                    addr_d    = req_idx;
                    kind_wr_d = 1'b0;
                    lat_d     = '0;
                    state_d   = ST_WAIT;
                end else if (cmd_in == C2_WRITE_LINE) begin
                    addr_d             = req_idx;
                    kind_wr_d          = 1'b1;
                    line_d[BUS_W-1:0]  = data_in;
                    beat_d             = BEAT_W'(1);
                    lat_d              = '0;
                    if (N_BEATS == 1) begin
                        ram_we    = 1'b1;
                        ram_waddr = req_idx;
                        state_d   = ST_WAIT;
                    end else begin
                        state_d   = ST_WR_CAP;
                    end
                end
            end

            ST_WR_CAP: begin
                // A broken write burst is flagged but the beat is still taken.
                if (cmd_in != C2_WRITE_LINE) begin
                    err_d = 1'b1;
                end
                for (int b = 0; b < N_BEATS; b++) begin
                    if (beat_q == BEAT_W'(b)) begin
                        line_d[b*BUS_W +: BUS_W] = data_in;
                    end
                end
                if (beat_q == BEAT_W'(N_BEATS - 1)) begin
                    ram_we  = 1'b1;
                    lat_d   = '0;
                    state_d = ST_WAIT;
                end else begin
                    beat_d  = beat_q + BEAT_W'(1);
                end
            end

            ST_WAIT: begin
                if (cmd_is_req) begin
                    err_d = 1'b1;
                end
                // Stays LATENCY+1 cycles: counts 0..LATENCY inclusive.
                if (lat_q == LAT_W'(LATENCY)) begin
                    beat_d  = '0;
                    state_d = kind_wr_q ? ST_RESP_WR : ST_RESP_RD;
                end else begin
                    lat_d   = lat_q + LAT_W'(1);
                end
            end

            ST_RESP_RD: begin
                if (cmd_is_req) begin
                    err_d = 1'b1;
                end
                if (beat_q == BEAT_W'(N_BEATS - 1)) begin
                    state_d = ST_RELEASE;
                end else begin
                    beat_d  = beat_q + BEAT_W'(1);
                end
            end

            ST_RESP_WR: begin
                if (cmd_is_req) begin
                    err_d = 1'b1;
                end
                state_d = ST_RELEASE;
            end

            ST_RELEASE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Bus outputs decode straight from state so async reset frees the bus at once.
    always_comb begin
        cmd_oe   = 1'b0;
        cmd_out  = C2_NOP;
        data_out = '0;
        case (state_q)
            ST_RESP_WR: begin
                cmd_oe  = 1'b1;
                cmd_out = C2_RESPONSE;
            end
            ST_RESP_RD: begin
                cmd_oe  = 1'b1;
                cmd_out = C2_RESPONSE;
                for (int b = 0; b < N_BEATS; b++) begin
                    if (beat_q == BEAT_W'(b)) begin
                        data_out = ram_rdata[b*BUS_W +: BUS_W];
                    end
                end
            end
            default: begin
                cmd_oe = 1'b0;
            end
        endcase
    end

    assign busy = (state_q != ST_IDLE);
    assign err  = err_q;

endmodule
